pwm_multi_channel: RTL and testbench

Memory-mapped, parametrised multi-channel PWM peripheral, the successor to the single-output PWM on the MIPS data bus. Sits behind one chip select from the address decoder and uses the same CS_N/RD_N/WR_N/Addr/DataIn/DataOut slave protocol as TimerCounter and GPIO. Adds N channels with a shared prescaled timebase, edge- or center-aligned counting, per-channel enable and polarity, double-buffered period/duty, and a period-end interrupt.

---
 rtl/pwm_multi_channel.sv | 175 +++++++++++++++++
 tb/tb_pwm_multi_channel.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM peripheral on the CS_N/RD_N/WR_N slave bus.
// All channels share one prescaled timebase with edge- or center-aligned
// counting. PERIOD and DUTY are double buffered: writes land in shadow
// registers, and the active copies reload at each period boundary. While the
// block is disabled, the active copies reload every cycle.
// Bus handshake: a write commits on the rising clk edge while CS_N=0 and
// WR_N=0. A read is combinational while CS_N=0 and RD_N=0. There is no wait
// state and no ready signal. DataOut is 0 whenever no read is selected.
module pwm_multi_channel #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int PSW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           CS_N,
  input  logic           RD_N,
  input  logic           WR_N,
  input  logic [11:0]    Addr,
  input  logic [31:0]    DataIn,
  output logic [31:0]    DataOut,
  output logic           Intr,
  output logic [NCH-1:0] pwm_out
);

  // Programmer-visible registers
  logic [2:0]     ctrl;
  logic [CW-1:0]  period_sh;
  logic [PSW-1:0] prescale;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] pol;
  logic [CW-1:0]  duty_sh [NCH];
  logic           pf;

  // Timebase state and active (double-buffered) copies
  logic [PSW-1:0] pcnt, pcnt_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           dir, dir_nxt;
  logic [CW-1:0]  per_a;
  logic [CW-1:0]  duty_a [NCH];
  logic           tick, boundary, load_active;

  logic       en, mode, ie;
  logic       addr_ok, wr_en;
  logic [5:0] idx;
  logic       unused_bits;

  assign en   = ctrl[0];
  assign mode = ctrl[1];
  assign ie   = ctrl[2];

  assign addr_ok = (Addr[11:8] == 4'd0);
  assign idx     = Addr[7:2];
  assign wr_en   = !CS_N && !WR_N && addr_ok;
  assign unused_bits = ^{Addr[1:0], DataIn};

  assign load_active = !en || boundary;
  assign Intr        = pf && ie;

  // Register writes from the bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl      <= '0;
      period_sh <= '0;
      prescale  <= '0;
      ch_en     <= '0;
      pol       <= '0;
      for (int i = 0; i < NCH; i++) duty_sh[i] <= '0;
    end else if (wr_en) begin
      if (idx == 6'd0) ctrl      <= DataIn[2:0];
      if (idx == 6'd1) period_sh <= DataIn[CW-1:0];
      if (idx == 6'd2) prescale  <= DataIn[PSW-1:0];
      if (idx == 6'd5) ch_en     <= DataIn[NCH-1:0];
      if (idx == 6'd6) pol       <= DataIn[NCH-1:0];
      for (int i = 0; i < NCH; i++)
        if (idx == 6'(8 + i)) duty_sh[i] <= DataIn[CW-1:0];
    end
  end

  // Next timebase state: prescaler tick, counter step, direction, boundary
  always_comb begin
    tick     = (pcnt >= prescale);  // >= recovers if PRESCALE shrinks mid-count
    pcnt_nxt = tick ? '0 : pcnt + PSW'(1);
    cnt_nxt  = cnt;
    dir_nxt  = mode ? dir : 1'b0;   // edge mode always counts up
    boundary = 1'b0;
    if (!en) begin
      pcnt_nxt = '0;
      cnt_nxt  = '0;
      dir_nxt  = 1'b0;
    end else if (tick) begin
      if (!mode) begin
        if (cnt >= per_a) begin
          cnt_nxt  = '0;
          boundary = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end else if (per_a == '0) begin
        cnt_nxt  = '0;
        dir_nxt  = 1'b0;
        boundary = 1'b1;
      end else if (!dir) begin
        if (cnt >= per_a) begin
          dir_nxt = 1'b1;
          cnt_nxt = cnt - CW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end else if (cnt == '0) begin
        // Bottom of the triangle: the new period starts climbing right away
        boundary = 1'b1;
        dir_nxt  = 1'b0;
        cnt_nxt  = (period_sh == '0) ? '0 : CW'(1);
      end else begin
        cnt_nxt = cnt - CW'(1);
      end
    end
  end

  // Timebase registers, active copies and period-end flag (set beats W1C)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt  <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      per_a <= '0;
      pf    <= 1'b0;
      for (int i = 0; i < NCH; i++) duty_a[i] <= '0;
    end else begin
      pcnt <= pcnt_nxt;
      cnt  <= cnt_nxt;
      dir  <= dir_nxt;
      if (load_active) begin
        per_a <= period_sh;
        for (int i = 0; i < NCH; i++) duty_a[i] <= duty_sh[i];
      end
      if (boundary)
        pf <= 1'b1;
      else if (wr_en && idx == 6'd3 && DataIn[0])
        pf <= 1'b0;
    end
  end

  // Registered outputs: compare against the active duty, then apply polarity
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        pwm_out[i] <= (en && ch_en[i]) ? ((cnt < duty_a[i]) ^ pol[i]) : pol[i];
    end
  end

  // Combinational read mux; PERIOD and DUTY return their shadow values
  always_comb begin
    DataOut = '0;
    if (!CS_N && !RD_N && addr_ok) begin
      case (idx)
        6'd0: DataOut = {29'd0, ctrl};
        6'd1: DataOut = 32'(period_sh);
        6'd2: DataOut = 32'(prescale);
        6'd3: DataOut = {30'd0, dir, pf};
        6'd4: DataOut = 32'(cnt);
        6'd5: DataOut = 32'(ch_en);
        6'd6: DataOut = 32'(pol);
        default: begin
          for (int i = 0; i < NCH; i++)
            if (idx == 6'(8 + i)) DataOut = 32'(duty_sh[i]);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel (NCH=4, CW=16, PSW=8).
// Expected values are pushed to exp_q before each stimulus step and popped
// when the DUT response is sampled 1 ns after the clock edge.
module tb_pwm_multi_channel;

  localparam logic [11:0] A_CTRL   = 12'h000;
  localparam logic [11:0] A_PERIOD = 12'h004;
  localparam logic [11:0] A_PRESC  = 12'h008;
  localparam logic [11:0] A_STATUS = 12'h00C;
  localparam logic [11:0] A_COUNT  = 12'h010;
  localparam logic [11:0] A_CHEN   = 12'h014;
  localparam logic [11:0] A_POL    = 12'h018;
  localparam logic [11:0] A_DUTY0  = 12'h020;

  logic        clk0 = 1'b0;
  logic        reset;
  logic        CS_N, RD_N, WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn, DataOut;
  logic        Intr;
  logic [3:0]  pwm_out;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Model state for the edge-mode phase
  int   k = 0;
  int   d1_act = 3;
  int   d1_sh = 3;
  logic pol0_m = 1'b0;
  logic ie_m = 1'b0;
  logic pf_m = 1'b0;
  logic [31:0] d;

  pwm_multi_channel #(.NCH(4), .CW(16), .PSW(8)) dut (
    .clk(clk0), .reset(reset), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
    .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut), .Intr(Intr),
    .pwm_out(pwm_out)
  );

  // Clock
  always #5 clk0 = ~clk0;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk0);
    #1;
    k++;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] v);
    CS_N = 1'b0; WR_N = 1'b0; Addr = a; DataIn = v;
    cyc();
    CS_N = 1'b1; WR_N = 1'b1; DataIn = '0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    CS_N = 1'b0; RD_N = 1'b0; Addr = a;
    #1;
    v = DataOut;
    CS_N = 1'b1; RD_N = 1'b1;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_rd(input string tag, input logic [11:0] a, input logic [31:0] e);
    logic [31:0] v;
    exp_q.push_back(e);
    rd(a, v);
    check(tag, v);
  endtask

  // One edge-mode cycle: PERIOD=9, PRESCALE=0, DUTY={15,10,d1,0}
  task automatic edge_steps(input int n);
    for (int s = 0; s < n; s++) begin
      int prev;
      prev = k % 10;
      exp_q.push_back({28'd0, 1'b1, 1'b1, (prev < d1_act), pol0_m});
      if (prev == 9) begin
        d1_act = d1_sh;
        pf_m   = 1'b1;
      end
      exp_q.push_back(32'((prev + 1) % 10));
      exp_q.push_back({30'd0, 1'b0, pf_m});
      exp_q.push_back({31'd0, pf_m & ie_m});
      cyc();
      check("edge_pwm", {28'd0, pwm_out});
      rd(A_COUNT, d);  check("edge_count", d);
      rd(A_STATUS, d); check("edge_status", d);
      check("edge_intr", {31'd0, Intr});
    end
  endtask

  function automatic int tri_s(input int j);
    int m;
    m = j % 8;
    return (m <= 4) ? m : 8 - m;
  endfunction

  initial begin
    reset = 1'b0; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
    Addr = '0; DataIn = '0;

    // Reset state
    cyc(); cyc();
    exp_q.push_back(32'd0); check("rst_pwm", {28'd0, pwm_out});
    exp_q.push_back(32'd0); check("rst_intr", {31'd0, Intr});
    check_rd("rst_ctrl", A_CTRL, 32'd0);
    check_rd("rst_count", A_COUNT, 32'd0);
    reset = 1'b1;
    cyc();

    // Edge-mode setup and register decode
    bus_write(A_PRESC, 32'd0);
    bus_write(A_PERIOD, 32'd9);
    bus_write(A_DUTY0 + 12'h0, 32'd0);
    bus_write(A_DUTY0 + 12'h4, 32'd3);
    bus_write(A_DUTY0 + 12'h8, 32'd10);
    bus_write(A_DUTY0 + 12'hC, 32'd15);
    bus_write(A_CHEN, 32'hF);
    check_rd("period_rd", A_PERIOD, 32'd9);
    check_rd("duty1_rd", A_DUTY0 + 12'h4, 32'd3);
    bus_write(12'h104, 32'd5);
    check_rd("hi_addr_write_ignored", A_PERIOD, 32'd9);
    check_rd("hi_addr_read_zero", 12'h104, 32'd0);
    bus_write(12'h030, 32'h1234);
    check_rd("unused_duty_slot", 12'h030, 32'd0);
    Addr = A_PERIOD; RD_N = 1'b0; #1;
    exp_q.push_back(32'd0); check("dataout_idle", DataOut);
    RD_N = 1'b1; #1;

    bus_write(A_CTRL, 32'd1);
    k = 0;
    edge_steps(25);

    // Double buffering: DUTY1=7 mid-period takes effect at the next boundary
    bus_write(A_DUTY0 + 12'h4, 32'd7);
    d1_sh = 7;
    check_rd("duty1_shadow_rd", A_DUTY0 + 12'h4, 32'd7);
    edge_steps(20);

    // Polarity: channel 0 disabled with POL0=1 idles high
    bus_write(A_POL, 32'd1);
    bus_write(A_CHEN, 32'hE);
    pol0_m = 1'b1;
    edge_steps(4);

    // Interrupt: clear PF off-boundary, enable IE, then W1C on a boundary
    edge_steps((15 - k % 10) % 10);
    bus_write(A_STATUS, 32'd1);
    pf_m = 1'b0;
    bus_write(A_CTRL, 32'd5);
    ie_m = 1'b1;
    edge_steps((19 - k % 10) % 10);
    bus_write(A_STATUS, 32'd1);
    pf_m = 1'b1;
    d1_act = d1_sh;
    check_rd("w1c_vs_boundary_pf", A_STATUS, 32'd1);
    exp_q.push_back(32'd1); check("w1c_vs_boundary_intr", {31'd0, Intr});
    check_rd("w1c_vs_boundary_count", A_COUNT, 32'd0);
    edge_steps(12);

    // Disable mid-period
    bus_write(A_CTRL, 32'd0);
    cyc();
    check_rd("dis_count", A_COUNT, 32'd0);
    check_rd("dis_status", A_STATUS, {30'd0, 1'b0, pf_m});
    exp_q.push_back(32'd1); check("dis_pwm_pol", {28'd0, pwm_out});
    exp_q.push_back(32'd0); check("dis_intr", {31'd0, Intr});

    // Center mode: PERIOD=4, DUTY0=2, PRESCALE=1, only channel 0
    bus_write(A_STATUS, 32'd1);
    bus_write(A_POL, 32'd0);
    bus_write(A_CHEN, 32'd1);
    bus_write(A_PERIOD, 32'd4);
    bus_write(A_DUTY0, 32'd2);
    bus_write(A_PRESC, 32'd1);
    check_rd("ctr_pf_cleared", A_STATUS, 32'd0);
    bus_write(A_CTRL, 32'd7);
    k = 0;
    for (int s = 0; s < 36; s++) begin
      int   j1;
      logic dir_e, pf_e;
      j1    = (k + 1) / 2;
      dir_e = (j1 % 8 >= 5) || (j1 % 8 == 0 && j1 > 0);
      pf_e  = (k + 1) >= 18;
      exp_q.push_back({31'd0, tri_s(k / 2) < 2});
      exp_q.push_back(32'(tri_s(j1)));
      exp_q.push_back({30'd0, dir_e, pf_e});
      exp_q.push_back({31'd0, pf_e});
      cyc();
      check("ctr_pwm", {28'd0, pwm_out});
      rd(A_COUNT, d);  check("ctr_count", d);
      rd(A_STATUS, d); check("ctr_status", d);
      check("ctr_intr", {31'd0, Intr});
    end

    // Asynchronous reset mid-count
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(32'd0); check("arst_pwm", {28'd0, pwm_out});
    exp_q.push_back(32'd0); check("arst_intr", {31'd0, Intr});
    check_rd("arst_count", A_COUNT, 32'd0);
    check_rd("arst_ctrl", A_CTRL, 32'd0);
    check_rd("arst_period", A_PERIOD, 32'd0);
    check_rd("arst_duty0", A_DUTY0, 32'd0);
    check_rd("arst_status", A_STATUS, 32'd0);
    reset = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
